// File: rtl/mac_seq.sv
// mac_seq: multiply-accumulate sequencer on the MAC port of the shared
// 100 x 16-bit register bank.
//
// On start it reads vectors A and B from the bank one word per cycle. It
// accumulates the signed Q8.8 products into a 40-bit accumulator. It then
// writes sat16(acc >>> FRAC) back to the bank at dst and pulses done.
// A command whose operand or result range falls outside the bank does no
// bank traffic at all. It only reports done with err set.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           command strobe, sampled only while idle
//   base_a, base_b  first addresses of vectors A and B
//   len             element count (0..DEPTH)
//   dst             result address
//   busy            high in every state except idle
//   done            one-cycle completion pulse
//   err             range error, meaningful while done is high
//   mac_addr        bank address
//   read_mac        bank read request (data returns one cycle later)
//   write_mac       bank write enable
//   data_to_regs    bank write data
//   data_from_regs  bank read data, registered by the bank, 0 when not reading
//
// Every output is a flop. The next output values are decoded from the next
// state and next register contents, so no input reaches an output without
// passing through a register.

module mac_seq #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 100,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] dst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mac_addr,
  output logic              read_mac,
  output logic              write_mac,
  output logic [DATA_W-1:0] data_to_regs,
  input  logic [DATA_W-1:0] data_from_regs
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_ACC, S_WR, S_DONE
  } state_t;

  localparam int PROD_W = 2 * DATA_W;
  // One extra bit so that base + len cannot overflow before the compare.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Registered state and latched command
  state_t                     state, state_n;
  logic        [ADDR_W-1:0]   a_q, a_n, b_q, b_n, len_q, len_n, dst_q, dst_n;
  logic        [ADDR_W-1:0]   idx, idx_n;
  logic signed [ACC_W-1:0]    acc, acc_n;
  logic signed [DATA_W-1:0]   op_a, op_a_n;
  logic                       err_q, err_n;

  // Next output values
  logic                       busy_n, done_n, err_out_n, read_n, write_n;
  logic        [ADDR_W-1:0]   addr_n;
  logic        [DATA_W-1:0]   data_n;

  logic signed [PROD_W-1:0]   prod;
  logic        [ADDR_W:0]     end_a, end_b, idx_inc;
  logic                       range_err;

  function automatic logic [DATA_W-1:0] sat_q(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC;
    if (s > SAT_MAX)      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (s < SAT_MIN) return {1'b1, {(DATA_W-1){1'b0}}};
    else                  return s[DATA_W-1:0];
  endfunction

  assign prod    = op_a * $signed(data_from_regs);
  assign end_a   = {1'b0, base_a} + {1'b0, len};
  assign end_b   = {1'b0, base_b} + {1'b0, len};
  assign idx_inc = {1'b0, idx} + 1'b1;
  assign range_err = ((len != '0) && ((end_a > DEPTH_X) || (end_b > DEPTH_X)))
                   || ({1'b0, dst} >= DEPTH_X);

  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    len_n   = len_q;
    dst_n   = dst_q;
    idx_n   = idx;
    acc_n   = acc;
    op_a_n  = op_a;
    err_n   = err_q;

    case (state)
      S_IDLE: begin
        if (start) begin
          a_n   = base_a;
          b_n   = base_b;
          len_n = len;
          dst_n = dst;
          idx_n = '0;
          acc_n = '0;
          err_n = range_err;
          if (range_err)      state_n = S_DONE;
          else if (len == '0) state_n = S_WR;
          else                state_n = S_RD_A;
        end
      end
      S_RD_A: state_n = S_RD_B;
      S_RD_B: begin
        // Bank now returns the A word requested in RD_A.
        op_a_n  = $signed(data_from_regs);
        state_n = S_ACC;
      end
      S_ACC: begin
        // Bank now returns the B word requested in RD_B.
        acc_n   = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        idx_n   = idx_inc[ADDR_W-1:0];
        state_n = (idx_inc == {1'b0, len_q}) ? S_WR : S_RD_A;
      end
      S_WR:    state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    busy_n    = (state_n != S_IDLE);
    done_n    = (state_n == S_DONE);
    err_out_n = (state_n == S_DONE) && err_n;
    read_n    = (state_n == S_RD_A) || (state_n == S_RD_B);
    write_n   = (state_n == S_WR);
    addr_n    = '0;
    data_n    = '0;
    case (state_n)
      S_RD_A:  addr_n = a_n + idx_n;
      S_RD_B:  addr_n = b_n + idx_n;
      S_WR: begin
        addr_n = dst_n;
        data_n = sat_q(acc_n);
      end
      default: addr_n = '0;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      len_q        <= '0;
      dst_q        <= '0;
      idx          <= '0;
      acc          <= '0;
      op_a         <= '0;
      err_q        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      read_mac     <= 1'b0;
      write_mac    <= 1'b0;
      mac_addr     <= '0;
      data_to_regs <= '0;
    end else begin
      state        <= state_n;
      a_q          <= a_n;
      b_q          <= b_n;
      len_q        <= len_n;
      dst_q        <= dst_n;
      idx          <= idx_n;
      acc          <= acc_n;
      op_a         <= op_a_n;
      err_q        <= err_n;
      busy         <= busy_n;
      done         <= done_n;
      err          <= err_out_n;
      read_mac     <= read_n;
      write_mac    <= write_n;
      mac_addr     <= addr_n;
      data_to_regs <= data_n;
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// Directed testbench for mac_seq. It holds a behavioural model of the
// 100 x 16-bit bank: registered read data, 0 when not reading, and a write on
// the clock edge. Cycle 1 is the first cycle after the edge that samples start.
// All outputs are sampled on the falling edge.

module tb_mac_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [6:0]  base_a, base_b, len, dst;
  logic        busy, done, err;
  logic [6:0]  mac_addr;
  logic        read_mac, write_mac;
  logic [15:0] data_to_regs, data_from_regs;

  logic [15:0] mem [0:99];

  int n_checks = 0;
  int n_pass   = 0;

  mac_seq dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_a         (base_a),
    .base_b         (base_b),
    .len            (len),
    .dst            (dst),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .mac_addr       (mac_addr),
    .read_mac       (read_mac),
    .write_mac      (write_mac),
    .data_to_regs   (data_to_regs),
    .data_from_regs (data_from_regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model
  always @(posedge clk) begin
    if (write_mac && mac_addr < 7'd100) mem[mac_addr] <= data_to_regs;
    data_from_regs <= (read_mac && mac_addr < 7'd100) ? mem[mac_addr] : 16'h0000;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Called at a falling edge; start is sampled on the following rising edge.
  task automatic issue(input logic [6:0] a, input logic [6:0] b,
                       input logic [6:0] l, input logic [6:0] d);
    base_a = a; base_b = b; len = l; dst = d;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Observes cycles 1..max_cyc. It stops at the cycle where done is seen.
  // It can inject a stray start or a reset pulse in a given cycle (0 = none).
  task automatic observe(input int max_cyc, input int restart_cyc, input int reset_cyc,
                         output int done_cyc, output logic err_v,
                         output int wr_cyc, output logic [6:0] wr_addr,
                         output logic [15:0] wr_data,
                         output int n_rd, output int n_wr, output int n_bad);
    done_cyc = -1; err_v = 1'b0; wr_cyc = -1; wr_addr = '0; wr_data = '0;
    n_rd = 0; n_wr = 0; n_bad = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (read_mac) n_rd++;
      if (write_mac) begin
        n_wr++; wr_cyc = c; wr_addr = mac_addr; wr_data = data_to_regs;
      end
      if ((read_mac && write_mac) || ((read_mac || write_mac) && mac_addr >= 7'd100))
        n_bad++;
      if (reset_cyc > 0 && c == reset_cyc + 1)
        check("rst_mid_outputs",
              {busy, done, err, read_mac, write_mac, mac_addr, data_to_regs}, 64'h0);
      if (reset_cyc > 0 && c == reset_cyc)     reset = 1'b1;
      if (reset_cyc > 0 && c == reset_cyc + 1) reset = 1'b0;
      if (restart_cyc > 0 && c == restart_cyc) begin
        start = 1'b1; base_a = 7'd50; base_b = 7'd60; len = 7'd1; dst = 7'd30;
      end
      if (restart_cyc > 0 && c == restart_cyc + 1) start = 1'b0;
      if (done) begin
        done_cyc = c; err_v = err;
        break;
      end
    end
  endtask

  int          dc, wc, nr, nw, nb;
  logic        ev;
  logic [6:0]  wa;
  logic [15:0] wd;

  initial begin
    reset = 1'b1; start = 1'b0;
    base_a = '0; base_b = '0; len = '0; dst = '0;
    for (int i = 0; i < 100; i++) mem[i] = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {busy, done, err, read_mac, write_mac, mac_addr, data_to_regs}, 64'h0);
    reset = 1'b0;

    // 1. Basic dot product: 1.0*3.0 + 2.0*0.5 = 4.0
    mem[0] = 16'h0100; mem[1] = 16'h0200; mem[10] = 16'h0300; mem[11] = 16'h0080;
    @(negedge clk);
    issue(7'd0, 7'd10, 7'd2, 7'd20);
    observe(50, 0, 0, dc, ev, wc, wa, wd, nr, nw, nb);
    check("t1_done_cycle", dc, 8);
    check("t1_err", ev, 0);
    check("t1_write_cycle", wc, 7);
    check("t1_write_addr", wa, 20);
    check("t1_write_data", wd, 16'h0400);
    check("t1_reads", nr, 4);
    check("t1_bank", mem[20], 16'h0400);
    check("t1_bus_rules", nb, 0);

    // 2. Saturation, positive then negative
    mem[30] = 16'h7FFF; mem[31] = 16'h7FFF; mem[32] = 16'h8000;
    @(negedge clk);
    issue(7'd30, 7'd31, 7'd1, 7'd40);
    observe(50, 0, 0, dc, ev, wc, wa, wd, nr, nw, nb);
    check("t2_pos_done_cycle", dc, 5);
    check("t2_pos_data", wd, 16'h7FFF);
    check("t2_pos_bank", mem[40], 16'h7FFF);
    @(negedge clk);
    issue(7'd32, 7'd31, 7'd1, 7'd41);
    observe(50, 0, 0, dc, ev, wc, wa, wd, nr, nw, nb);
    check("t2_neg_done_cycle", dc, 5);
    check("t2_neg_data", wd, 16'h8000);
    check("t2_neg_bank", mem[41], 16'h8000);

    // 3. Zero length writes 0 immediately
    mem[5] = 16'h1234;
    @(negedge clk);
    issue(7'd0, 7'd0, 7'd0, 7'd5);
    observe(50, 0, 0, dc, ev, wc, wa, wd, nr, nw, nb);
    check("t3_write_cycle", wc, 1);
    check("t3_write_data", wd, 16'h0000);
    check("t3_done_cycle", dc, 2);
    check("t3_reads", nr, 0);
    check("t3_bank", mem[5], 16'h0000);

    // 4. Range errors: operand overrun, then dst out of range
    @(negedge clk);
    issue(7'd98, 7'd0, 7'd5, 7'd0);
    observe(50, 0, 0, dc, ev, wc, wa, wd, nr, nw, nb);
    check("t4a_done_cycle", dc, 1);
    check("t4a_err", ev, 1);
    check("t4a_reads", nr, 0);
    check("t4a_writes", nw, 0);
    @(negedge clk);
    check("t4a_err_cleared_idle", {busy, err}, 0);
    issue(7'd0, 7'd10, 7'd2, 7'd100);
    observe(50, 0, 0, dc, ev, wc, wa, wd, nr, nw, nb);
    check("t4b_done_cycle", dc, 1);
    check("t4b_err", ev, 1);
    check("t4b_traffic", nr + nw, 0);

    // 5. Stray start in cycle 3, then back-to-back start after done
    @(negedge clk);
    issue(7'd0, 7'd10, 7'd2, 7'd21);
    observe(50, 3, 0, dc, ev, wc, wa, wd, nr, nw, nb);
    check("t5_done_cycle", dc, 8);
    check("t5_write_addr", wa, 21);
    check("t5_write_data", wd, 16'h0400);
    check("t5_no_stray_write", mem[30], 16'h7FFF);
    @(negedge clk);
    check("t5_busy_after_done", busy, 0);
    issue(7'd0, 7'd10, 7'd1, 7'd22);
    observe(50, 0, 0, dc, ev, wc, wa, wd, nr, nw, nb);
    check("t5_next_done_cycle", dc, 5);
    check("t5_next_data", wd, 16'h0300);

    // 6. Reset in cycle 4 of a len=3 command
    mem[2] = 16'h0100; mem[12] = 16'h0100; mem[25] = 16'hBEEF;
    @(negedge clk);
    issue(7'd0, 7'd10, 7'd3, 7'd25);
    observe(15, 0, 4, dc, ev, wc, wa, wd, nr, nw, nb);
    check("t6_no_done", dc, -1);
    check("t6_no_write", nw, 0);
    check("t6_dst_unchanged", mem[25], 16'hBEEF);
    check("t6_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
